// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase-detector FSM states, saturation helper and
// the error width shared with the loop filter.
package adpll_pkg;

    localparam int ERROR_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REF_LEAD,
        ST_FB_LEAD
    } pd_state_t;

    // Largest magnitude of a symmetric signed range of the given width.
    function automatic int sat_of(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/phase_error_detector_if.sv
// Phase detector boundary: the two asynchronous clocks in, the error sample
// stream and lock flag out towards the loop filter.
interface phase_error_detector_if
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = ERROR_WIDTH_DEFAULT
);
    logic                          ref_clk_i;
    logic                          fb_clk_i;
    logic signed [ERROR_WIDTH-1:0] error_o;
    logic                          error_valid_o;
    logic                          lock_o;

    modport master (
        input  ref_clk_i,
        input  fb_clk_i,
        output error_o,
        output error_valid_o,
        output lock_o
    );

    modport slave (
        output ref_clk_i,
        output fb_clk_i,
        input  error_o,
        input  error_valid_o,
        input  lock_o
    );
endinterface

// File: rtl/phase_error_detector_edge_sync.sv
// Synchronises one asynchronous clock into gen_clk_i and produces a registered
// one-cycle pulse on each rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic gen_clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES:0]   arm_reg;
    logic                   hist_reg;
    logic                   rise_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge gen_clk_i or posedge reset_i) begin
                if (reset_i) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= async_i;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // Edges are only reported once the chain has refilled after reset, so an
    // input that is already high at release is not mistaken for a rising edge.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            arm_reg  <= '0;
            hist_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            arm_reg  <= {arm_reg[SYNC_STAGES-1:0], 1'b1};
            hist_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= arm_reg[SYNC_STAGES] & sync_reg[SYNC_STAGES-1] & ~hist_reg;
        end
    end

    assign rise_o = rise_reg;
endmodule

// File: rtl/phase_error_detector.sv
// Counts gen_clk_i cycles between reference and feedback rising edges and
// emits one saturated signed phase error per measurement, plus a lock flag.
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = ERROR_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_i,
    phase_error_detector_if.master pd
);
    localparam int                 CNT_W   = ERROR_WIDTH - 1;
    localparam int                 LK_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   SAT_CNT = CNT_W'(sat_of(ERROR_WIDTH));
    localparam logic [CNT_W-1:0]   THRESH  = CNT_W'(LOCK_THRESH);
    localparam logic [LK_W-1:0]    LK_MAX  = LK_W'(LOCK_COUNT);

    logic ref_edge;
    logic fb_edge;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .async_i   (pd.ref_clk_i),
        .rise_o    (ref_edge)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .async_i   (pd.fb_clk_i),
        .rise_o    (fb_edge)
    );

    pd_state_t                     state_reg, state_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic [LK_W-1:0]               lk_reg, lk_next;
    logic signed [ERROR_WIDTH-1:0] error_reg;
    logic                          valid_reg;
    logic                          lock_reg;

    logic                          emit;
    logic                          emit_neg;
    logic [CNT_W-1:0]              emit_mag;
    logic                          lead_edge;
    logic                          lag_edge;
    logic signed [ERROR_WIDTH-1:0] mag_val;
    logic signed [ERROR_WIDTH-1:0] emit_val;

    // Both lead states share one path; only edge roles and output sign differ.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        emit       = 1'b0;
        emit_mag   = cnt_reg;
        emit_neg   = (state_reg == ST_FB_LEAD);
        lead_edge  = (state_reg == ST_FB_LEAD) ? fb_edge  : ref_edge;
        lag_edge   = (state_reg == ST_FB_LEAD) ? ref_edge : fb_edge;
        case (state_reg)
            ST_IDLE: begin
                if (ref_edge && fb_edge) begin
                    emit     = 1'b1;
                    emit_mag = '0;
                end else if (ref_edge) begin
                    state_next = ST_REF_LEAD;
                    cnt_next   = CNT_W'(1);
                end else if (fb_edge) begin
                    state_next = ST_FB_LEAD;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_REF_LEAD, ST_FB_LEAD: begin
                if (lag_edge) begin
                    emit = 1'b1;
                    if (lead_edge) begin
                        cnt_next = CNT_W'(1);
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else if (lead_edge) begin
                    emit     = 1'b1;
                    emit_mag = SAT_CNT;
                    cnt_next = CNT_W'(1);
                end else if (cnt_reg == SAT_CNT) begin
                    emit       = 1'b1;
                    emit_mag   = SAT_CNT;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign mag_val  = {1'b0, emit_mag};
    assign emit_val = emit_neg ? -mag_val : mag_val;

    always_comb begin
        lk_next = lk_reg;
        if (emit) begin
            if (emit_mag <= THRESH) begin
                lk_next = (lk_reg == LK_MAX) ? lk_reg : lk_reg + LK_W'(1);
            end else begin
                lk_next = '0;
            end
        end
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            lk_reg    <= '0;
            error_reg <= '0;
            valid_reg <= 1'b0;
            lock_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            lk_reg    <= lk_next;
            valid_reg <= emit;
            lock_reg  <= (lk_next == LK_MAX);
            if (emit) begin
                error_reg <= emit_val;
            end
        end
    end

    assign pd.error_o       = error_reg;
    assign pd.error_valid_o = valid_reg;
    assign pd.lock_o        = lock_reg;
endmodule
